// File: rtl/pipelined_rotate_shift_unit.sv
// Pipelined ROR/ROL/SHR/SHRA/SHL barrel shifter; log2(WIDTH) levels spread over STAGES register stages.
// Latency: STAGES cycles, one op per cycle. Backpressure: global stall, in_ready = !out_valid || out_ready.
// Optional: define SHIFTER_FLAGS_EN to add out_zero / out_carry result flags.
module pipelined_rotate_shift_unit #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_value,
    input  logic [CW-1:0]    in_count,
    input  logic [2:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result
`ifdef SHIFTER_FLAGS_EN
    ,
    output logic             out_zero,
    output logic             out_carry
`endif
);

    logic             advance;
    logic             in_rev;
    logic [WIDTH-1:0] src_dat  [STAGES];
    logic [WIDTH-1:0] nxt_dat  [STAGES];
    logic [WIDTH-1:0] r_dat    [STAGES];
    logic [CW-1:0]    src_cnt  [STAGES];
    logic [CW-1:0]    r_cnt    [STAGES];
    logic             src_vld  [STAGES];
    logic             r_vld    [STAGES];
    logic             src_rot  [STAGES];
    logic             r_rot    [STAGES];
    logic             src_fill [STAGES];
    logic             r_fill   [STAGES];
    logic             src_rev  [STAGES];
    logic             r_rev    [STAGES];
`ifdef SHIFTER_FLAGS_EN
    logic             src_carry [STAGES];
    logic             r_carry   [STAGES];
    logic             r_zero;
    logic [CW-1:0]    neg_cnt;
    logic [CW-1:0]    dec_cnt;
`endif

    function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        for (int k = 0; k < WIDTH; k++) r[k] = d[WIDTH-1-k];
        return r;
    endfunction

    // One right-going network level: rotate, zero-fill or sign-fill by sh.
    function automatic logic [WIDTH-1:0] lvl(input logic [WIDTH-1:0] d, input int sh,
                                             input logic rot, input logic fill);
        logic [WIDTH-1:0] hi;
        if (rot)       hi = d << (WIDTH - sh);
        else if (fill) hi = ~({WIDTH{1'b1}} >> sh);
        else           hi = '0;
        return (d >> sh) | hi;
    endfunction

    assign advance    = !r_vld[STAGES-1] || out_ready;
    assign in_ready   = advance;
    assign out_valid  = r_vld[STAGES-1];
    assign out_result = r_dat[STAGES-1];
    // Left-going modes run through the right-going network on a bit-reversed operand.
    assign in_rev     = (in_mode == 3'd1) || (in_mode == 3'd4);

    always_comb begin
        src_dat[0]  = in_rev ? bitrev(in_value) : in_value;
        src_cnt[0]  = (in_mode > 3'd4) ? '0 : in_count;
        src_vld[0]  = in_valid;
        src_rot[0]  = (in_mode == 3'd0) || (in_mode == 3'd1);
        src_fill[0] = (in_mode == 3'd3) && in_value[WIDTH-1];
        src_rev[0]  = in_rev;
`ifdef SHIFTER_FLAGS_EN
        neg_cnt = -in_count;
        dec_cnt = in_count - 1'b1;
        if (in_mode > 3'd4 || in_count == '0) src_carry[0] = 1'b0;
        else if (in_rev)                      src_carry[0] = in_value[neg_cnt];
        else                                  src_carry[0] = in_value[dec_cnt];
`endif
        for (int s = 1; s < STAGES; s++) begin
            src_dat[s]  = r_dat[s-1];
            src_cnt[s]  = r_cnt[s-1];
            src_vld[s]  = r_vld[s-1];
            src_rot[s]  = r_rot[s-1];
            src_fill[s] = r_fill[s-1];
            src_rev[s]  = r_rev[s-1];
`ifdef SHIFTER_FLAGS_EN
            src_carry[s] = r_carry[s-1];
`endif
        end
        for (int s = 0; s < STAGES; s++) begin
            nxt_dat[s] = src_dat[s];
            for (int i = 0; i < CW; i++) begin
                if (((i * STAGES) / CW) == s && src_cnt[s][i])
                    nxt_dat[s] = lvl(nxt_dat[s], 1 << i, src_rot[s], src_fill[s]);
            end
            if (s == STAGES - 1 && src_rev[s]) nxt_dat[s] = bitrev(nxt_dat[s]);
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            for (int s = 0; s < STAGES; s++) begin
                r_dat[s]  <= '0;
                r_cnt[s]  <= '0;
                r_vld[s]  <= 1'b0;
                r_rot[s]  <= 1'b0;
                r_fill[s] <= 1'b0;
                r_rev[s]  <= 1'b0;
`ifdef SHIFTER_FLAGS_EN
                r_carry[s] <= 1'b0;
`endif
            end
`ifdef SHIFTER_FLAGS_EN
            r_zero <= 1'b0;
`endif
        end else if (advance) begin
            for (int s = 0; s < STAGES; s++) begin
                r_dat[s]  <= nxt_dat[s];
                r_cnt[s]  <= src_cnt[s];
                r_vld[s]  <= src_vld[s];
                r_rot[s]  <= src_rot[s];
                r_fill[s] <= src_fill[s];
                r_rev[s]  <= src_rev[s];
`ifdef SHIFTER_FLAGS_EN
                r_carry[s] <= src_carry[s];
`endif
            end
`ifdef SHIFTER_FLAGS_EN
            r_zero <= (nxt_dat[STAGES-1] == '0);
`endif
        end
    end

`ifdef SHIFTER_FLAGS_EN
    assign out_zero  = r_zero;
    assign out_carry = r_carry[STAGES-1];
`endif

endmodule

// File: tb/tb_pipelined_rotate_shift_unit.sv
// Self-checking bench for pipelined_rotate_shift_unit (WIDTH=32, STAGES=2) with a scoreboard model.
module tb_pipelined_rotate_shift_unit;
    localparam int W  = 32;
    localparam int ST = 2;
    localparam int CW = 5;

    logic          clock = 1'b0;
    logic          clear_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_value = '0;
    logic [CW-1:0] in_count = '0;
    logic [2:0]    in_mode = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_result;
`ifdef SHIFTER_FLAGS_EN
    logic          out_zero;
    logic          out_carry;
`endif

    typedef struct packed {
        logic [W-1:0] res;
        logic         carry;
        logic         zero;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   outs = 0;

    always #5 clock = ~clock;

    pipelined_rotate_shift_unit #(.WIDTH(W), .STAGES(ST)) dut (
        .clock      (clock),
        .clear_n    (clear_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_value   (in_value),
        .in_count   (in_count),
        .in_mode    (in_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
`ifdef SHIFTER_FLAGS_EN
        ,
        .out_zero   (out_zero),
        .out_carry  (out_carry)
`endif
    );

    function automatic logic [W-1:0] model_res(input logic [W-1:0] v, input int c, input int m);
        logic [2*W-1:0] w;
        w = {v, v};
        case (m)
            0: begin w = w >> c; return w[W-1:0]; end
            1: begin w = w << c; return w[2*W-1:W]; end
            2: return v >> c;
            3: return $unsigned($signed(v) >>> c);
            4: return v << c;
            default: return v;
        endcase
    endfunction

    function automatic logic model_carry(input logic [W-1:0] v, input int c, input int m);
        if (c == 0 || m > 4) return 1'b0;
        if (m == 1 || m == 4) return v[W-c];
        return v[c-1];
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Evaluate handshakes away from the edge, then advance one clock.
    task automatic tick();
        exp_t e;
        #1;
        if (out_valid && out_ready) begin
            outs++;
            if (exp_q.size() == 0) begin
                chk("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("result", out_result, e.res);
`ifdef SHIFTER_FLAGS_EN
                chk("zero_flag", 32'(out_zero), 32'(e.zero));
                chk("carry_flag", 32'(out_carry), 32'(e.carry));
`endif
            end
        end
        if (in_valid && in_ready) begin
            e.res   = model_res(in_value, int'(in_count), int'(in_mode));
            e.carry = model_carry(in_value, int'(in_count), int'(in_mode));
            e.zero  = (e.res == '0);
            exp_q.push_back(e);
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive(input logic [W-1:0] v, input int c, input int m);
        in_value = v;
        in_count = CW'(c);
        in_mode  = 3'(m);
        in_valid = 1'b1;
    endtask

    task automatic directed(input string tag, input logic [W-1:0] v, input int c, input int m,
                            input logic [W-1:0] expv);
        drive(v, c, m);
        tick();
        in_valid = 1'b0;
        for (int k = 1; k < ST; k++) begin
            #1;
            chk({tag, "_early"}, 32'(out_valid), 32'd0);
            tick();
        end
        #1;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk(tag, out_result, expv);
        tick();
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) tick();
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int outs_before;
        int cnt0_modes[6] = '{0, 1, 2, 3, 4, 6};

        // Reset state
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef SHIFTER_FLAGS_EN
        chk("rst_zero", 32'(out_zero), 32'd0);
        chk("rst_carry", 32'(out_carry), 32'd0);
`endif
        @(negedge clock);
        clear_n = 1'b1;
        @(negedge clock);

        directed("ror1", 32'h8000_0001, 1, 0, 32'hC000_0000);
        directed("rol8", 32'h1234_5678, 8, 1, 32'h3456_7812);
        directed("ror8", 32'h1234_5678, 8, 0, 32'h7812_3456);
        directed("shra31", 32'h8000_0000, 31, 3, 32'hFFFF_FFFF);
        directed("shr31", 32'h8000_0000, 31, 2, 32'h0000_0001);
        directed("shl31", 32'h0000_0001, 31, 4, 32'h8000_0000);
        foreach (cnt0_modes[j]) directed("cnt0", 32'hDEAD_BEEF, 0, cnt0_modes[j], 32'hDEAD_BEEF);
        directed("pass7", 32'h0F0F_1234, 13, 7, 32'h0F0F_1234);

        // Four back-to-back ops with a three-cycle output stall
        outs_before = outs;
        for (int j = 0; j < 3; j++) begin
            drive($urandom, int'($urandom_range(0, 31)), int'($urandom_range(0, 4)));
            tick();
        end
        drive($urandom, int'($urandom_range(0, 31)), int'($urandom_range(0, 4)));
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_hold", out_result, exp_q[0].res);
            @(posedge clock);
            @(negedge clock);
        end
        out_ready = 1'b1;
        tick();
        drain();
        chk("stream_count", 32'(outs - outs_before), 32'd4);

        // Random traffic with random backpressure
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_value  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            in_count  = CW'($urandom_range(0, 31));
            in_mode   = 3'($urandom_range(0, 7));
            tick();
        end
        drain();

        // Asynchronous reset with operations in flight
        drive(32'hCAFE_F00D, 4, 0);
        tick();
        drive(32'h1357_9BDF, 9, 4);
        tick();
        in_valid = 1'b0;
        #2;
        clear_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_result", out_result, 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        @(negedge clock);
        clear_n = 1'b1;
        @(negedge clock);
        #1;
        chk("postrst_idle", 32'(out_valid), 32'd0);
        @(negedge clock);
        directed("postrst_op", 32'hA5A5_0001, 1, 0, 32'hD2D2_8000);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
